// File: rtl/adding_machine_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adding_machine_pkg
// Brief    : Shared widths, arbiter state encoding and requester ids.
// Revision : 1.0 - initial release
// ============================================================================
package adding_machine_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_CPU = 1'b0;
  localparam req_id_t REQ_LDR = 1'b1;

  function automatic req_id_t rr_other(input req_id_t id);
    return ~id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : CPU port, loader port and shared memory bus of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
  import adding_machine_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_ack, ldr_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata,
    output busy
  );

  // Requesters and memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_ack, ldr_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Combinational two-way round-robin picker.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import adding_machine_pkg::*;
(
  input  logic    req_cpu,
  input  logic    req_ldr,
  input  req_id_t last_grant,
  output req_id_t grant,
  output logic    valid
);

  // On a tie the side that did not win last time goes first.
  always_comb begin
    grant = REQ_CPU;
    if (req_cpu && req_ldr) begin
      grant = rr_other(last_grant);
    end else if (req_ldr) begin
      grant = REQ_LDR;
    end
  end

  assign valid = req_cpu | req_ldr;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one fixed-latency memory between a CPU and a loader port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import adding_machine_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] C_CNT_LOAD = 4'(WAIT_CYCLES - 1);

  arb_state_t        r_state;
  logic [3:0]        r_count;
  req_id_t           r_last_grant;
  req_id_t           r_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_cpu_ack;
  logic              r_ldr_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ldr_rdata;
  logic              r_busy;

  req_id_t           w_grant;
  logic              w_valid;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req_cpu    (bus.cpu_req),
    .req_ldr    (bus.ldr_req),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .valid      (w_valid)
  );

  always_comb begin
    w_sel_we    = bus.cpu_we;
    w_sel_addr  = bus.cpu_addr;
    w_sel_wdata = bus.cpu_wdata;
    if (w_grant == REQ_LDR) begin
      w_sel_we    = bus.ldr_we;
      w_sel_addr  = bus.ldr_addr;
      w_sel_wdata = bus.ldr_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= 4'd0;
      r_last_grant <= REQ_LDR;
      r_grant      <= REQ_CPU;
      r_we         <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_ldr_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ldr_rdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cpu_ack <= 1'b0;
          r_ldr_ack <= 1'b0;
          if (w_valid) begin
            r_state      <= ST_ACCESS;
            r_count      <= C_CNT_LOAD;
            r_grant      <= w_grant;
            r_last_grant <= w_grant;
            r_we         <= w_sel_we;
            r_mem_addr   <= w_sel_addr;
            r_mem_wdata  <= w_sel_wdata;
            r_mem_read   <= ~w_sel_we;
            r_mem_write  <= w_sel_we;
            r_busy       <= 1'b1;
          end
        end

        ST_ACCESS: begin
          if (r_count == 4'd0) begin
            // Final access cycle: read data is valid on the bus now.
            if (!r_we) begin
              if (r_grant == REQ_LDR) begin
                r_ldr_rdata <= bus.mem_rdata;
              end else begin
                r_cpu_rdata <= bus.mem_rdata;
              end
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_cpu_ack   <= (r_grant == REQ_CPU);
            r_ldr_ack   <= (r_grant == REQ_LDR);
            r_state     <= ST_ACK;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end

        ST_ACK: begin
          r_cpu_ack <= 1'b0;
          r_ldr_ack <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_cpu_ack   <= 1'b0;
          r_ldr_ack   <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.ldr_ack   = r_ldr_ack;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.ldr_rdata = r_ldr_rdata;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, memory access latency in cycles, legal range 1..15.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 cpu_req  input  1  controller memory request, held until cpu_ack.
REQ-005 cpu_we  input  1  1 = write, 0 = read; sampled at grant.
REQ-006 cpu_addr  input  5  word address; sampled at grant.
REQ-007 cpu_wdata  input  8  write data; sampled at grant.
REQ-008 cpu_ack  output  1  one-cycle completion pulse.
REQ-009 cpu_rdata  output  8  read data; valid from cpu_ack and held until the next CPU read completes.
REQ-010 ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata: program-loader port, same widths and meanings as the CPU port.
REQ-011 mem_addr  output  5  memory address.
REQ-012 mem_wdata  output  8  memory write data.
REQ-013 mem_read  output  1  memory read strobe.
REQ-014 mem_write  output  1  memory write strobe.
REQ-015 mem_rdata  input  8  memory read data.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, ACCESS, ACK.
- IDLE -> ACCESS when any request is high.
- ACCESS -> ACK after WAIT_CYCLES cycles.
- ACK -> IDLE unconditionally.
REQ-018 Grant decision in IDLE:
- Single requester: that requester is granted.
- Both requesting: the requester not granted last is granted (round-robin).
- A last_grant register records the winner.
REQ-019 On grant, the winner's we/addr/wdata are captured into internal registers; later changes on the ports are ignored until ACK.
REQ-020 ACCESS lasts exactly WAIT_CYCLES cycles, timed by a 4-bit down-counter loaded with WAIT_CYCLES-1.
- mem_addr and mem_wdata come from the captured registers.
- mem_read = ~we and mem_write = we, held for every ACCESS cycle.
REQ-021 On the final ACCESS cycle of a read, mem_rdata is captured into the granted port's rdata register.
- Writes leave rdata unchanged.
REQ-022 In ACK, exactly one cycle, only the granted port's ack is high; mem_read and mem_write are low.
REQ-023 Latency: request first seen high in IDLE at cycle 0 -> ACCESS in cycles 1..WAIT_CYCLES -> ack in cycle WAIT_CYCLES+1.
REQ-024 Minimum request-to-request spacing is WAIT_CYCLES+2 cycles; no back-to-back pipelining.
REQ-025 A req still high in the IDLE cycle after ACK counts as a new request.
REQ-026 If the granted requester drops req during ACCESS, the access still completes and ack still pulses.
REQ-027 In IDLE, all memory strobes and acks are 0 and mem_addr/mem_wdata hold their last values.
REQ-028 mem_read and mem_write are never high together; cpu_ack and ldr_ack are never high together.

Reset
REQ-029 On reset, at any time including mid-ACCESS:
- State -> IDLE and the counter -> 0.
- last_grant -> LDR, so the CPU wins the first tie.
- All acks, strobes and busy -> 0.
- mem_addr, mem_wdata, cpu_rdata and ldr_rdata -> 0.
REQ-030 An access aborted by reset produces no ack; the requester must re-request.

Structure
REQ-031 The shared package adding_machine_pkg holds:
- ADDR_W=5 and DATA_W=8.
- The arbiter state enum.
- Requester id constants REQ_CPU=0 and REQ_LDR=1.
REQ-032 One sub-module, rr_arb2: a combinational two-way round-robin picker (inputs: two requests and last_grant; outputs: grant id and valid), instantiated once.

Verification
REQ-033 Single CPU read with WAIT_CYCLES=2: cpu_req, addr=5'h03, memory returns 8'hA5 -> mem_read high for 2 cycles, then cpu_ack in cycle 3 with cpu_rdata=8'hA5.
REQ-034 Loader write: ldr_we=1, addr=5'h1F, wdata=8'h3C -> mem_write high for WAIT_CYCLES cycles with mem_addr=5'h1F and mem_wdata=8'h3C, then ldr_ack; cpu_rdata and ldr_rdata unchanged.
REQ-035 Both requests held continuously after reset -> grants alternate CPU, LDR, CPU, LDR; each ack is spaced WAIT_CYCLES+2 cycles apart.
REQ-036 Reset asserted in the second ACCESS cycle of a CPU read -> busy, mem_read and cpu_ack go to 0 immediately; no ack follows; the next tie is granted to the CPU.
REQ-037 With WAIT_CYCLES=1, cpu_req dropped in the ACCESS cycle -> cpu_ack still pulses in cycle 2; mem_read lasts exactly 1 cycle.
